// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM encoding, transfer mode and the
// slave-select index width helper.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    // A single slave still needs a one-bit index port.
    function automatic int unsigned sel_width(input int unsigned nss);
        return (nss > 1) ? $clog2(nss) : 1;
    endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// SCLK half-period generator: one-cycle tick every div_i+1 clocks while
// enabled; the count restarts whenever the enable is low.
module spi_clkdiv
#(
    parameter int unsigned DIVW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [DIVW-1:0] div_i,
    output logic            half_tick_c
);

    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] cnt_d;

    always_comb begin
        half_tick_c = en_i && (cnt_q == div_i);
        cnt_d       = cnt_q + DIVW'(1);
        if (!en_i || half_tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_ctrl.sv
// SPI master with configurable width, slave count, mode, SCLK divider and
// bit order; CPU-facing load/unload strobes with rx_valid/overrun status.
module spi_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned NSS  = 2,
    parameter int unsigned DIVW = 8
) (
    input  logic                        clock_in,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        unload,
    input  logic [DW-1:0]               datain,
    input  logic [sel_width(NSS)-1:0]   sel,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic                        lsb_first,
    input  logic [DIVW-1:0]             div,
    output logic [DW-1:0]               dataout,
    output logic                        busy,
    output logic                        rx_valid,
    output logic                        overrun,
    output logic                        sclk,
    output logic                        mosi,
    input  logic                        miso,
    output logic [NSS-1:0]              ssn_out
);

    localparam int unsigned HW = $clog2(2 * DW);

    state_e          state_q, state_d;
    mode_t           mode_q, mode_d;
    logic            lsb_q, lsb_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [DW-1:0]   tx_q, tx_d;
    logic [DW-1:0]   rx_q, rx_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic [NSS-1:0]  ssn_q, ssn_d;
    logic            busy_q, busy_d;
    logic            rx_valid_q, rx_valid_d;
    logic            overrun_q, overrun_d;
    logic [DW-1:0]   dataout_q, dataout_d;

    logic            half_tick;
    logic            lead_c;
    logic            trail_c;
    logic [DW-1:0]   din_ord_c;
    logic [DW-1:0]   rx_ord_c;
    logic [NSS-1:0]  ssn_sel_c;

    spi_clkdiv #(
        .DIVW (DIVW)
    ) u_clkdiv (
        .clk_i       (clock_in),
        .rst_i       (reset),
        .en_i        (state_q != ST_IDLE),
        .div_i       (div_q),
        .half_tick_c (half_tick)
    );

    // Both shift registers always work MSB-end first; order is fixed up here.
    always_comb begin
        din_ord_c = datain;
        rx_ord_c  = rx_q;
        if (lsb_first) begin
            for (int unsigned i = 0; i < DW; i++) begin
                din_ord_c[i] = datain[DW-1-i];
            end
        end
        if (lsb_q) begin
            for (int unsigned i = 0; i < DW; i++) begin
                rx_ord_c[i] = rx_q[DW-1-i];
            end
        end
    end

    // An out-of-range index matches no bit, so every select stays high.
    always_comb begin
        ssn_sel_c = '1;
        for (int unsigned i = 0; i < NSS; i++) begin
            if (32'(sel) == i) begin
                ssn_sel_c[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lsb_d      = lsb_q;
        div_d      = div_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        hcnt_d     = hcnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ssn_d      = ssn_q;
        busy_d     = busy_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        dataout_d  = dataout_q;
        lead_c     = 1'b0;
        trail_c    = 1'b0;

        if (unload) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol;
                if (load) begin
                    state_d = ST_SETUP;
                    busy_d  = 1'b1;
                    mode_d  = '{cpol: cpol, cpha: cpha};
                    lsb_d   = lsb_first;
                    div_d   = div;
                    hcnt_d  = '0;
                    rx_d    = '0;
                    ssn_d   = ssn_sel_c;
                    if (!cpha) begin
                        mosi_d = din_ord_c[DW-1];
                        tx_d   = din_ord_c << 1;
                    end else begin
                        tx_d   = din_ord_c;
                    end
                end
            end
            ST_SETUP: begin
                if (half_tick) begin
                    state_d = ST_XFER;
                    lead_c  = 1'b1;
                end
            end
            ST_XFER: begin
                // Edge at the start of each XFER half-period; even ones lead.
                if (half_tick) begin
                    if (hcnt_q == HW'(2 * DW - 1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        hcnt_d  = hcnt_q + HW'(1);
                        lead_c  = hcnt_q[0];
                        trail_c = ~hcnt_q[0];
                    end
                end
            end
            ST_HOLD: begin
                if (half_tick) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    ssn_d      = '1;
                    sclk_d     = mode_q.cpol;
                    dataout_d  = rx_ord_c;
                    rx_valid_d = 1'b1;
                    // A same-cycle unload consumed the old word: nothing lost.
                    overrun_d  = overrun_q | (rx_valid_q & ~unload);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (lead_c || trail_c) begin
            sclk_d = ~sclk_q;
        end
        if ((lead_c && mode_q.cpha) || (trail_c && !mode_q.cpha)) begin
            mosi_d = tx_q[DW-1];
            tx_d   = tx_q << 1;
        end
        if ((lead_c && !mode_q.cpha) || (trail_c && mode_q.cpha)) begin
            rx_d = {rx_q[DW-2:0], miso};
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            lsb_q      <= 1'b0;
            div_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            hcnt_q     <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ssn_q      <= '1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            dataout_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lsb_q      <= lsb_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            hcnt_q     <= hcnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ssn_q      <= ssn_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            dataout_q  <= dataout_d;
        end
    end

    assign dataout  = dataout_q;
    assign busy     = busy_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ssn_out  = ssn_q;

endmodule

// File: doc/spi_ctrl.md
# spi_ctrl

Parametrised SPI master peripheral for the LnL SoC: successor to the fixed 8-bit single-slave `spi`, adding configurable word width, multiple slave selects, all four CPOL/CPHA modes, a programmable SCLK divider, MSB/LSB-first order and a receive-valid/overrun status. It sits behind the CPU address decoder: `load` and `unload` are the decoded write and read strobes, `datain` and `dataout` connect to the CPU data bus, and the SPI pins go to `uio`.

## Interface
- `DW`, 8: transfer word width in bits (≥2).
- `NSS`, 2: number of active-low slave-select outputs (≥1).
- `DIVW`, 8: width of the divider configuration.
- `clock_in`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle strobe: start a transfer of `datain`.
- `unload`  in  1  one-cycle strobe: CPU has consumed `dataout`; clears `rx_valid` and `overrun`.
- `datain`  in  DW  transmit word, sampled on `load`.
- `sel`  in  max(1,$clog2(NSS))  slave index, sampled on `load`.
- `cpol`, `cpha`, `lsb_first`  in  1 each  mode bits, sampled on `load`.
- `div`  in  DIVW  SCLK half-period = `div`+1 clocks, sampled on `load`.
- `dataout`  out  DW  last received word.
- `busy`, `rx_valid`, `overrun`  out  1 each  status.
- `sclk`, `mosi`  out  1 each  SPI clock and data out.
- `miso`  in  1  SPI data in.
- `ssn_out`  out  NSS  active-low slave selects.

## Operation
- Reset values: `busy`=0, `rx_valid`=0, `overrun`=0, `dataout`=0, `sclk`=0, `mosi`=0, `ssn_out`=all ones; FSM in IDLE.
- FSM states: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE: `sclk` tracks the `cpol` input (registered). `load` moves the FSM to SETUP and latches the word, `sel` and mode bits.
- SETUP: `ssn_out[sel]`=0 and `sclk`=cpol for one half-period. When cpha=0, the first bit is driven on `mosi`.
- XFER: 2·DW half-periods, with `sclk` toggling at each half-period boundary.
  - cpha=0: `miso` is sampled on leading edges; the next bit is shifted onto `mosi` on trailing edges.
  - cpha=1: the bit is shifted onto `mosi` on leading edges; `miso` is sampled on trailing edges.
- Bit order: MSB first unless `lsb_first`=1, which applies to both directions.
- HOLD: `sclk`=cpol and `ssn` stays low for one half-period. Then `ssn_out` goes all ones, `dataout` is loaded with the received word, `rx_valid`=1, and the FSM returns to IDLE.
- `load` while `busy`: ignored, with no side effects.
- Completion while `rx_valid`=1: `dataout` is overwritten and `overrun` is set. `overrun` is sticky until `unload` or `reset`.
- `unload` in the same cycle as completion: completion wins, so `rx_valid` stays 1, `overrun` is unchanged, and the new word is kept.
- `sel` ≥ NSS: the transfer runs normally, but no `ssn_out` bit is asserted.
- `reset` mid-transfer: all outputs return to reset values on the next edge, the transfer is abandoned and `dataout` is not updated.
- `div` counter wraps only at `div`; `div`=0 gives SCLK = `clock_in`/2.

## Timing
- `load` sampled at edge T → at T+1: `busy`=1 and `ssn` asserted.
- Busy duration: exactly (2·DW+2)·(div+1) cycles. Example: DW=8, div=0 gives 18 cycles.
- `busy` falls, `rx_valid` rises and `dataout` updates on the same edge as `ssn_out` deasserts.
- A `load` on the first cycle with `busy`=0 is accepted, giving back-to-back transfers with one idle cycle.
- `unload` clears the status flags on the next edge.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `spi_pkg`: FSM state encoding (IDLE, SETUP, XFER, HOLD), a mode typedef {cpol, cpha}, and a helper constant for the `sel` width.
- Sub-module `spi_clkdiv`:
  - Inputs: `div` and an enable.
  - Outputs: a one-cycle `half_tick` every `div`+1 clocks, restarting on enable.
- Top level holds the FSM, TX/RX shift registers, bit counter and status flags.

## Test plan
- Mode 0, DW=8, div=0, sel=1, datain=0xA5, slave returns 0x3C → `mosi` shows 1010_0101, `dataout`=0x3C, `ssn_out`=2'b01 during the transfer, `busy` high for 18 cycles.
- Modes 1/2/3 with div=3, lsb_first=1, datain=0x81 → correct edge polarity, `sclk` idle level = cpol, `busy` high for 72 cycles.
- Two transfers without `unload` → `overrun`=1 and `dataout` = second word. A subsequent `unload` → `rx_valid`=0 and `overrun`=0.
- `load` while busy with 0xFF → first transfer unaffected, 0xFF never sent.
- `reset` asserted in mid-XFER → next cycle `ssn_out`=all ones, `busy`=0, `sclk`=0, `dataout` keeps 0.
- `unload` coincident with completion → `rx_valid` stays 1 and `overrun` stays 0.
